// File: rtl/m6502_bus_pkg.sv
// Shared types and constants for the 6502 downstream bus bridge and its decoders.
package m6502_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAM  = 2'd1,
    S_IO   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic {
    REG_RAM = 1'b0,
    REG_IO  = 1'b1
  } region_t;

  // Read data returned to the core when an I/O access times out
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

  // RAM wait counter must hold the largest legal RAM_WAIT
  localparam int RAM_WAIT_MAX = 7;
  localparam int RAM_CNT_W    = $clog2(RAM_WAIT_MAX + 1);

  // Width of a counter that counts 0 .. n-1
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/m6502_bus_decode.sv
// Page-range region decoder: addr[15:8] inside [PAGE_LO, PAGE_HI] selects I/O,
// everything else is RAM. Purely combinational so other bus masters can share it.
import m6502_bus_pkg::*;

module m6502_bus_decode #(
  parameter logic [7:0] PAGE_LO = 8'hD0,
  parameter logic [7:0] PAGE_HI = 8'hDF
) (
  input  logic [7:0] page,
  output region_t    region
);

  // Inclusive range compare on the page byte
  always_comb begin
    region = ((page >= PAGE_LO) && (page <= PAGE_HI)) ? REG_IO : REG_RAM;
  end

endmodule

// File: rtl/m6502_bus_bridge.sv
// 6502 downstream bus bridge: accepts single-cycle read/write strobes in IDLE,
// runs a fixed-wait RAM access or an ack-handshaked I/O access, returns read
// data and drives the core's ready. All outputs are registered.
// Optional: define M6502_BUS_TIMEOUT_EN to abort I/O accesses that see no ack
// within TIMEOUT cycles (bus_error pulse, read data forced to 8'hFF).
import m6502_bus_pkg::*;

module m6502_bus_bridge #(
  parameter int unsigned RAM_WAIT   = 1,
  parameter logic [7:0]  IO_PAGE_LO = 8'hD0,
  parameter logic [7:0]  IO_PAGE_HI = 8'hDF,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd_req,
  input  logic        cpu_wr_en,
  input  logic [7:0]  cpu_wr_data,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_page,
  output logic        io_sel,
  output logic        io_we,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  output logic        bus_error
);

  if (RAM_WAIT < 1 || RAM_WAIT > RAM_WAIT_MAX || TIMEOUT < 1) begin : g_param_check
    $error("m6502_bus_bridge: RAM_WAIT must be 1..7 and TIMEOUT at least 1");
  end

  state_t                 state;
  state_t                 state_nxt;
  region_t                region;
  logic [RAM_CNT_W-1:0]   ram_cnt;
  logic                   is_wr;
  logic                   accept;
  logic                   ram_done;
  logic                   io_done;
  logic                   to_expire;

  m6502_bus_decode #(
    .PAGE_LO (IO_PAGE_LO),
    .PAGE_HI (IO_PAGE_HI)
  ) u_decode (
    .page   (cpu_addr[15:8]),
    .region (region)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (region == REG_IO) ? S_IO : S_RAM;
      S_RAM:  if (ram_done) state_nxt = S_DONE;
      S_IO:   if (io_done || to_expire) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Per-state event strobes that steer the registered outputs
  always_comb begin
    accept   = (state == S_IDLE) && (cpu_rd_req || cpu_wr_en);
    ram_done = (state == S_RAM) && (ram_cnt == '0);
    io_done  = (state == S_IO) && io_ack;
  end

  // Registered bus outputs, latched request and RAM wait counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_ready   <= 1'b1;
      cpu_rd_data <= 8'h00;
      mem_addr    <= 16'h0000;
      mem_cs      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= 8'h00;
      io_addr     <= 8'h00;
      io_page     <= 8'h00;
      io_sel      <= 1'b0;
      io_we       <= 1'b0;
      io_wdata    <= 8'h00;
      ram_cnt     <= '0;
      is_wr       <= 1'b0;
    end else begin
      // RAM strobes are single-cycle pulses
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      if (accept) begin
        is_wr     <= cpu_wr_en;
        cpu_ready <= 1'b0;
        ram_cnt   <= RAM_CNT_W'(RAM_WAIT);
        if (region == REG_IO) begin
          io_page <= cpu_addr[15:8];
          io_addr <= cpu_addr[7:0];
          io_sel  <= 1'b1;
          io_we   <= cpu_wr_en;
          if (cpu_wr_en) io_wdata <= cpu_wr_data;
        end else begin
          mem_addr <= cpu_addr;
          mem_cs   <= 1'b1;
          mem_we   <= cpu_wr_en;
          if (cpu_wr_en) mem_wdata <= cpu_wr_data;
        end
      end
      if (state == S_RAM) begin
        if (ram_done) begin
          cpu_ready <= 1'b1;
          if (!is_wr) cpu_rd_data <= mem_rdata;
        end else begin
          ram_cnt <= ram_cnt - 1'b1;
        end
      end
      // An ack on the expiry edge wins over the timeout
      if (io_done) begin
        io_sel    <= 1'b0;
        io_we     <= 1'b0;
        cpu_ready <= 1'b1;
        if (!is_wr) cpu_rd_data <= io_rdata;
      end else if (to_expire) begin
        io_sel    <= 1'b0;
        io_we     <= 1'b0;
        cpu_ready <= 1'b1;
        if (!is_wr) cpu_rd_data <= TIMEOUT_FILL;
      end
    end
  end

`ifdef M6502_BUS_TIMEOUT_EN
  localparam int TO_CNT_W = cnt_width(TIMEOUT);
  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

  logic [TO_CNT_W-1:0] to_cnt;
  logic                bus_error_q;

  assign to_expire = (state == S_IO) && !io_ack && (to_cnt == TO_LAST);
  assign bus_error = bus_error_q;

  // Count cycles spent waiting in IO and pulse bus_error on expiry
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      bus_error_q <= to_expire;
      if (state == S_IO) to_cnt <= to_cnt + 1'b1;
      else               to_cnt <= '0;
    end
  end
`else
  assign to_expire = 1'b0;
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_m6502_bus_bridge.sv
// Directed testbench for m6502_bus_bridge (default parameters, RAM_WAIT=1).
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_m6502_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic        cpu_rd_req;
  logic        cpu_wr_en;
  logic [7:0]  cpu_wr_data;
  logic [7:0]  cpu_rd_data;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic        mem_cs;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [7:0]  io_addr;
  logic [7:0]  io_page;
  logic        io_sel;
  logic        io_we;
  logic [7:0]  io_wdata;
  logic [7:0]  io_rdata;
  logic        io_ack;
  logic        bus_error;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  m6502_bus_bridge dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_rd_req  (cpu_rd_req),
    .cpu_wr_en   (cpu_wr_en),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rd_data (cpu_rd_data),
    .cpu_ready   (cpu_ready),
    .mem_addr    (mem_addr),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .io_addr     (io_addr),
    .io_page     (io_page),
    .io_sel      (io_sel),
    .io_we       (io_we),
    .io_wdata    (io_wdata),
    .io_rdata    (io_rdata),
    .io_ack      (io_ack),
    .bus_error   (bus_error)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for cpu_ready, then step through DONE back to IDLE
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cpu_ready && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 16'(cpu_ready), 16'h1);
    tick();
  endtask

  // Issue a one-cycle strobe at the current cycle; returns in cycle T+1
  task automatic request(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [7:0] wdata);
    cpu_addr    = addr;
    cpu_rd_req  = rd;
    cpu_wr_en   = wr;
    cpu_wr_data = wdata;
    tick();
    cpu_rd_req  = 1'b0;
    cpu_wr_en   = 1'b0;
  endtask

  // Read one address and confirm which region the bridge chose
  task automatic probe_region(input string tag, input logic [15:0] addr, input logic exp_io);
    request(addr, 1'b1, 1'b0, 8'h00);
    chk({tag, "_io_sel"}, 16'(io_sel), 16'(exp_io));
    chk({tag, "_mem_cs"}, 16'(mem_cs), 16'(!exp_io));
    if (exp_io) begin
      io_ack = 1'b1;
      tick();
      io_ack = 1'b0;
    end
    wait_ready({tag, "_done"});
  endtask

  initial begin
    logic saw_err;
    logic saw_ready;
    reset       = 1'b1;
    cpu_addr    = 16'h0000;
    cpu_rd_req  = 1'b0;
    cpu_wr_en   = 1'b0;
    cpu_wr_data = 8'h00;
    mem_rdata   = 8'h00;
    io_rdata    = 8'h00;
    io_ack      = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready",   16'(cpu_ready),   16'h1);
    chk("rst_rd_data", 16'(cpu_rd_data), 16'h00);
    chk("rst_mem_cs",  16'(mem_cs),      16'h0);
    chk("rst_io_sel",  16'(io_sel),      16'h0);
    chk("rst_berr",    16'(bus_error),   16'h0);
    chk("rst_mem_addr", mem_addr,        16'h0000);

    // 1. RAM read 1234 -> A9
    request(16'h1234, 1'b1, 1'b0, 8'h00);
    mem_rdata = 8'hA9;
    chk("rd_cs_t1",    16'(mem_cs),   16'h1);
    chk("rd_we_t1",    16'(mem_we),   16'h0);
    chk("rd_addr_t1",  mem_addr,      16'h1234);
    chk("rd_ready_t1", 16'(cpu_ready), 16'h0);
    tick();
    chk("rd_cs_t2",    16'(mem_cs),   16'h0);
    chk("rd_ready_t2", 16'(cpu_ready), 16'h0);
    tick();
    chk("rd_ready_t3", 16'(cpu_ready), 16'h1);
    chk("rd_data",     16'(cpu_rd_data), 16'h00A9);
    tick();

    // 2. RAM write 0200 <- 5C, read data must not change
    request(16'h0200, 1'b0, 1'b1, 8'h5C);
    mem_rdata = 8'h77;
    chk("wr_cs",    16'(mem_cs),  16'h1);
    chk("wr_we",    16'(mem_we),  16'h1);
    chk("wr_addr",  mem_addr,     16'h0200);
    chk("wr_wdata", 16'(mem_wdata), 16'h005C);
    tick();
    chk("wr_cs_t2", 16'(mem_cs),  16'h0);
    chk("wr_we_t2", 16'(mem_we),  16'h0);
    tick();
    chk("wr_ready", 16'(cpu_ready), 16'h1);
    chk("wr_rd_keep", 16'(cpu_rd_data), 16'h00A9);
    tick();

    // Both strobes high: write wins
    request(16'h0300, 1'b1, 1'b1, 8'h11);
    chk("both_we", 16'(mem_we), 16'h1);
    wait_ready("both_done");
    chk("both_rd_keep", 16'(cpu_rd_data), 16'h00A9);

    // 3. IO read D012, ack in the 5th IO cycle; a request mid-access is dropped
    request(16'hD012, 1'b1, 1'b0, 8'h00);
    chk("io_page", 16'(io_page), 16'h00D0);
    chk("io_addr", 16'(io_addr), 16'h0012);
    chk("io_we",   16'(io_we),   16'h0);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("io_sel_c%0d", i), 16'(io_sel), 16'h1);
      chk($sformatf("io_rdy_c%0d", i), 16'(cpu_ready), 16'h0);
      chk($sformatf("io_cs_c%0d", i),  16'(mem_cs), 16'h0);
      cpu_rd_req = (i == 2);
      cpu_addr   = (i == 2) ? 16'h0400 : cpu_addr;
      if (i == 5) begin
        io_ack   = 1'b1;
        io_rdata = 8'h3E;
      end
      tick();
    end
    io_ack = 1'b0;
    chk("io_ready_a1", 16'(cpu_ready), 16'h1);
    chk("io_sel_a1",   16'(io_sel),    16'h0);
    chk("io_rd_data",  16'(cpu_rd_data), 16'h003E);
    tick();

    // 4. Page boundaries
    probe_region("pg_CFFF", 16'hCFFF, 1'b0);
    probe_region("pg_E000", 16'hE000, 1'b0);
    probe_region("pg_DFFF", 16'hDFFF, 1'b1);

    // 5. Reset in the second IO cycle; later ack ignored
    request(16'hD005, 1'b1, 1'b0, 8'h00);
    tick();
    chk("rm_io_sel_pre", 16'(io_sel), 16'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_io_sel",  16'(io_sel),      16'h0);
    chk("rm_ready",   16'(cpu_ready),   16'h1);
    chk("rm_rd_data", 16'(cpu_rd_data), 16'h00);
    io_ack   = 1'b1;
    io_rdata = 8'h55;
    tick();
    io_ack = 1'b0;
    tick();
    chk("rm_ack_ready", 16'(cpu_ready),   16'h1);
    chk("rm_ack_data",  16'(cpu_rd_data), 16'h00);
    chk("rm_ack_sel",   16'(io_sel),      16'h0);
    mem_rdata = 8'hC3;
    request(16'h0010, 1'b1, 1'b0, 8'h00);
    chk("rm_idle_cs", 16'(mem_cs), 16'h1);
    wait_ready("rm_idle_done");
    chk("rm_idle_data", 16'(cpu_rd_data), 16'h00C3);

`ifdef M6502_BUS_TIMEOUT_EN
    // 6. IO read with no ack: timeout after 64 IO cycles
    request(16'hD100, 1'b1, 1'b0, 8'h00);
    saw_err   = 1'b0;
    saw_ready = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      saw_err   |= bus_error;
      saw_ready |= cpu_ready;
      if (i < 64) tick();
    end
    chk("to_no_early_err",   16'(saw_err),   16'h0);
    chk("to_no_early_ready", 16'(saw_ready), 16'h0);
    chk("to_sel_last",       16'(io_sel),    16'h1);
    tick();
    chk("to_berr",    16'(bus_error),   16'h1);
    chk("to_ready",   16'(cpu_ready),   16'h1);
    chk("to_sel",     16'(io_sel),      16'h0);
    chk("to_rd_data", 16'(cpu_rd_data), 16'h00FF);
    tick();
    chk("to_berr_once", 16'(bus_error), 16'h0);
`else
    // Without the timeout option the IO access waits indefinitely
    request(16'hD100, 1'b1, 1'b0, 8'h00);
    saw_err   = 1'b0;
    saw_ready = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      saw_err   |= bus_error;
      saw_ready |= cpu_ready;
      if (i < 80) tick();
    end
    chk("nto_no_err",   16'(saw_err),   16'h0);
    chk("nto_no_ready", 16'(saw_ready), 16'h0);
    chk("nto_sel_held", 16'(io_sel),    16'h1);
    io_ack   = 1'b1;
    io_rdata = 8'h42;
    tick();
    io_ack = 1'b0;
    chk("nto_ready",   16'(cpu_ready),   16'h1);
    chk("nto_rd_data", 16'(cpu_rd_data), 16'h0042);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m6502_bus_bridge.md
Name: m6502_bus_bridge

Overview:
Downstream bus interface for the 6502 core. It accepts the core's single-cycle rd_req / wr_en strobes and decodes the address into one of two regions: synchronous RAM with a fixed wait count, or an I/O page window with an ack handshake. It runs the access, returns rd_data, and drives the core's ready. It sits between the CPU and the system memory/IO fabric.

Parameters:
RAM_WAIT, 1, extra RAM cycles after chip-select; legal range 1..7; 1 suits a single-cycle synchronous RAM.
IO_PAGE_LO, 8'hD0, first page (addr[15:8]) of the I/O window, inclusive.
IO_PAGE_HI, 8'hDF, last page of the I/O window, inclusive.
TIMEOUT, 64, I/O ack timeout in cycles; used only with the optional feature.

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
cpu_addr  in  16  CPU address
cpu_rd_req  in  1  read strobe
cpu_wr_en  in  1  write strobe
cpu_wr_data  in  8  write data
cpu_rd_data  out  8  read data, held until the next read completes
cpu_ready  out  1  high = idle or previous access complete
mem_addr  out  16  RAM address
mem_cs  out  1  RAM chip-select, one-cycle pulse
mem_we  out  1  RAM write enable, qualified by mem_cs
mem_wdata  out  8  RAM write data
mem_rdata  in  8  RAM read data, valid the cycle after mem_cs
io_addr  out  8  I/O register offset (cpu_addr[7:0])
io_page  out  8  I/O page (cpu_addr[15:8])
io_sel  out  1  I/O select, held until ack
io_we  out  1  I/O write, qualified by io_sel
io_wdata  out  8  I/O write data
io_rdata  in  8  I/O read data, valid with io_ack
io_ack  in  1  I/O completion
bus_error  out  1  one-cycle pulse on I/O timeout; tied 0 without the optional feature

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, cpu_ready=1, cpu_rd_data=8'h00, mem_cs=0, mem_we=0, io_sel=0, io_we=0, bus_error=0, address and write-data outputs 0.
- States: IDLE, RAM, IO, DONE.
- IDLE:
  - A request is cpu_rd_req | cpu_wr_en. Requests are sampled only in IDLE; requests arriving in any other state are dropped, not queued.
  - If both strobes are high, write wins.
  - On accept at edge T: latch address, direction and write data; cpu_ready=0 from cycle T+1.
  - Region decode: IO when IO_PAGE_LO <= addr[15:8] <= IO_PAGE_HI, otherwise RAM.
- RAM:
  - Occupies cycles T+1 .. T+1+RAM_WAIT. mem_cs=1 in cycle T+1 only; mem_we=1 in that cycle for writes.
  - A down-counter loaded with RAM_WAIT runs; at the edge where it reaches 0, go to DONE.
  - On reads, capture mem_rdata into cpu_rd_data at that edge.
- IO:
  - io_sel/io_we are asserted from T+1 and held until io_ack is sampled high.
  - On the ack edge: capture io_rdata (reads only), drop io_sel/io_we, go to DONE.
  - An ack while not in IO is ignored.
- DONE: cpu_ready=1; next state IDLE.
  - Net RAM latency: request at cycle T gives cpu_ready high at T+2+RAM_WAIT.
  - Net IO latency: ack at cycle A gives cpu_ready high at A+1.
  - The DONE cycle does not sample requests. Minimum spacing between back-to-back accesses is the access length plus one cycle.
- Data rules: writes never modify cpu_rd_data. mem_addr and io_* address outputs hold their last value when idle.
- Reset mid-access: the access is abandoned immediately and all outputs take their reset values on the next edge; no strobe is left asserted.

Optional Feature:
Macro: M6502_BUS_TIMEOUT_EN.
- Defined: a cycle counter runs while in IO. If io_ack has not arrived after TIMEOUT cycles in IO:
  - drop io_sel;
  - pulse bus_error for one cycle;
  - on reads, set cpu_rd_data=8'hFF;
  - go to DONE.
  An ack arriving on the same edge as expiry takes priority: normal completion, no error.
- Undefined: IO waits for ack indefinitely; bus_error is constant 0 and no counter is synthesised.

Decomposition:
- Package m6502_bus_pkg:
  - state encoding (IDLE/RAM/IO/DONE);
  - region enum (REG_RAM/REG_IO);
  - the 8'hFF timeout fill value;
  - counter width constants derived from RAM_WAIT and TIMEOUT.
- Sub-module m6502_bus_decode: combinational page-range compare of addr[15:8], producing the region. It is reused by future DMA/video masters.

Test Plan:
1. RAM read, RAM_WAIT=1: read 16'h1234 with mem_rdata=8'hA9 -> mem_cs pulses at T+1; cpu_ready low T+1..T+2 and high at T+3; cpu_rd_data=8'hA9.
2. RAM write 16'h0200 <- 8'h5C -> one mem_cs/mem_we pulse with mem_addr=16'h0200 and mem_wdata=8'h5C; cpu_rd_data unchanged.
3. IO read 16'hD012 with ack delayed 5 cycles and io_rdata=8'h3E -> io_page=8'hD0, io_addr=8'h12; io_sel held 5 cycles; cpu_ready high the cycle after ack; cpu_rd_data=8'h3E.
4. Page boundaries: 16'hCFFF -> RAM; 16'hE000 -> RAM; 16'hDFFF -> IO.
5. reset asserted in the second cycle of an IO access -> next edge gives io_sel=0, cpu_ready=1, state IDLE; a later ack has no effect.
6. With M6502_BUS_TIMEOUT_EN and TIMEOUT=64: IO read, no ack -> after 64 cycles, bus_error pulses once, cpu_rd_data=8'hFF, cpu_ready=1.
